// File: rtl/dummy_accelerator_result_fifo.sv
// rtl/dummy_accelerator_result_fifo.sv - in-order result queue between accelerator CU and core result port

module dummy_accelerator_result_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int RD_WIDTH   = 5,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic [RD_WIDTH-1:0]   rd_i,
    input  logic                  we_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ID_WIDTH-1:0]   id_o,
    output logic [RD_WIDTH-1:0]   rd_o,
    output logic                  we_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + ID_WIDTH + RD_WIDTH + 1;

    typedef logic [ENTRY_W-1:0] entry_t;

    entry_t               storage [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    entry_t head;

    // Occupancy flags come from the counter so a full queue and an empty one
    // never alias when the pointers coincide.
    assign full  = (count == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    // A full queue still accepts when the core drains the head this cycle;
    // flush blocks both sides so nothing is exchanged on the kill edge.
    assign ready_o = ~flush_i & (~full | ready_i);
    assign valid_o = ~flush_i & ~empty;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    // Head is read straight from storage (no fall-through), zeroed when empty.
    assign head = empty ? '0 : storage[rd_ptr];
    assign {data_o, id_o, rd_o, we_o} = head;

    assign count_o = count;
    assign empty_o = empty;
    assign full_o  = full;

    // Pointer and occupancy bookkeeping; reset beats flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately left unreset; only accepted pushes write it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            storage[wr_ptr] <= {data_i, id_i, rd_i, we_i};
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && full && !pop));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && empty));

    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count <= CNT_WIDTH'(DEPTH));

endmodule
